sonar_bus_master: RTL

- Bus initiator for the SonarOnChip register interface (valid/adr/dat/strb out, ack/dat in). Drives NUM_INST SonarOnChip slaves.
- Accepts single read/write commands from a host-side valid/ready channel and executes one bus access at a time.
- Returns read data or a timeout error on a response channel.
- Supports a broadcast write that programs the same register (e.g. IIR/FIR coefficients, threshold) in every instance, one instance after another.

---
 rtl/sonar_bus_pkg.sv | 28 ++
 rtl/sonar_bus_timeout.sv | 31 +++
 rtl/sonar_bus_master.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sonar_bus_pkg.sv
// Shared constants for the SonarOnChip register-bus master: bus geometry,
// slave register map and master FSM state encoding.
package sonar_bus_pkg;

    localparam int BUS_WIDTH  = 16;
    localparam int ADDR_WIDTH = 4;

    localparam logic [ADDR_WIDTH-1:0] REG_CONTROL   = 4'd0;
    localparam logic [ADDR_WIDTH-1:0] REG_A0        = 4'd1;
    localparam logic [ADDR_WIDTH-1:0] REG_A1        = 4'd2;
    localparam logic [ADDR_WIDTH-1:0] REG_A2        = 4'd3;
    localparam logic [ADDR_WIDTH-1:0] REG_B1        = 4'd4;
    localparam logic [ADDR_WIDTH-1:0] REG_B2        = 4'd5;
    localparam logic [ADDR_WIDTH-1:0] REG_AMP       = 4'd6;
    localparam logic [ADDR_WIDTH-1:0] REG_THRESHOLD = 4'd7;
    localparam logic [ADDR_WIDTH-1:0] REG_TIMER     = 4'd8;
    localparam logic [ADDR_WIDTH-1:0] REG_PCM       = 4'd9;
    localparam logic [ADDR_WIDTH-1:0] REG_PCM_LOAD  = 4'd10;
    localparam logic [ADDR_WIDTH-1:0] REG_FB0       = 4'd11;
    localparam logic [ADDR_WIDTH-1:0] REG_FB1       = 4'd12;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_GAP    = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/sonar_bus_timeout.sv
// Ack watchdog: reloads on entry to an access and counts down while the
// access is outstanding; expired marks the last cycle of the wait window.
module sonar_bus_timeout
    import sonar_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] START = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= START;
        end else if (load) begin
            cnt <= START;
        end else if (en && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sonar_bus_master.sv
// SonarOnChip register-bus master: executes one host command at a time and
// walks a broadcast write across every slave instance in turn.
module sonar_bus_master
    import sonar_bus_pkg::*;
#(
    parameter int NUM_INST = 4,
    parameter int IW       = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_n_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_we_i,
    input  logic                          cmd_bcast_i,
    input  logic [IW-1:0]                 cmd_inst_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_adr_i,
    input  logic [BUS_WIDTH-1:0]          cmd_dat_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [BUS_WIDTH-1:0]          rsp_dat_o,
    output logic                          rsp_err_o,
    output logic [IW-1:0]                 rsp_inst_o,
    output logic [NUM_INST-1:0]           m_valid_o,
    output logic [ADDR_WIDTH-1:0]         m_adr_o,
    output logic [BUS_WIDTH-1:0]          m_dat_o,
    output logic                          m_strb_o,
    input  logic [NUM_INST-1:0]           m_ack_i,
    input  logic [BUS_WIDTH*NUM_INST-1:0] m_dat_i,
    output logic                          busy_o
);
    state_t               state;
    logic [IW-1:0]        cur;
    logic [IW-1:0]        fail_inst;
    logic [IW-1:0]        nxt_inst;
    logic [IW-1:0]        start_inst;
    logic                 bcast_q;
    logic                 err_q;
    logic                 ack_sel;
    logic                 expired;
    logic                 accept;
    logic                 cmd_bad;
    logic                 last_inst;
    logic                 tmo_load;
    logic [BUS_WIDTH-1:0] dat_sel;

    function automatic logic [NUM_INST-1:0] inst_onehot(input logic [IW-1:0] idx);
        logic [NUM_INST-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            if (idx == IW'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Only the selected lane counts, and only while we drive its valid:
    // stale or floating acks on other lanes are ignored.
    always_comb begin
        ack_sel = 1'b0;
        dat_sel = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            if (cur == IW'(i)) begin
                ack_sel = m_ack_i[i] & m_valid_o[i];
                dat_sel = m_dat_i[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    assign accept     = cmd_valid_i & cmd_ready_o;
    assign cmd_bad    = (int'(cmd_inst_i) >= NUM_INST) | (cmd_bcast_i & ~cmd_we_i);
    assign start_inst = cmd_bcast_i ? '0 : cmd_inst_i;
    assign nxt_inst   = cur + IW'(1);
    assign last_inst  = (cur == IW'(NUM_INST - 1));
    assign tmo_load   = ((state == ST_IDLE) & accept & ~cmd_bad) | (state == ST_GAP);
    assign busy_o     = (state != ST_IDLE);

    sonar_bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .load   (tmo_load),
        .en     (state == ST_ACCESS),
        .expired(expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= ST_IDLE;
            cur         <= '0;
            fail_inst   <= '0;
            bcast_q     <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_inst_o  <= '0;
            m_valid_o   <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            m_strb_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (accept) begin
                        cmd_ready_o <= 1'b0;
                        bcast_q     <= cmd_bcast_i;
                        err_q       <= 1'b0;
                        cur         <= start_inst;
                        fail_inst   <= start_inst;
                        if (cmd_bad) begin
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_dat_o   <= '0;
                            rsp_inst_o  <= cmd_inst_i;
                        end else begin
                            state     <= ST_ACCESS;
                            m_valid_o <= inst_onehot(start_inst);
                            m_adr_o   <= cmd_adr_i;
                            m_dat_o   <= cmd_dat_i;
                            m_strb_o  <= cmd_we_i;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack takes priority over an expiry landing on the same edge.
                    if (ack_sel || expired) begin
                        m_valid_o <= '0;
                        if (!ack_sel) begin
                            err_q <= 1'b1;
                            if (!err_q) fail_inst <= cur;
                        end
                        if (!bcast_q || last_inst) begin
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= err_q | ~ack_sel;
                            rsp_inst_o  <= err_q ? fail_inst : cur;
                            rsp_dat_o   <= (ack_sel && !m_strb_o && !bcast_q) ? dat_sel : '0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // One idle cycle lets the previous slave's registered ack clear.
                    state     <= ST_ACCESS;
                    cur       <= nxt_inst;
                    m_valid_o <= inst_onehot(nxt_inst);
                end
                default: begin
                    if (rsp_ready_i) begin
                        state       <= ST_IDLE;
                        cmd_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b0;
                        rsp_inst_o  <= '0;
                    end
                end
            endcase
        end
    end

endmodule
